forward_write_arbiter: RTL and testbench
========================================

FORWARD_WRITE_ARBITER -- requirements
Module: forward_write_arbiter

Interface
REQ-001 SHALL have parameter masters, default 2, meaning number of crossbar master ports.
REQ-002 SHALL have parameter slaves, default 2, meaning number of crossbar slave ports.
REQ-003 SHALL have parameter i_am_slave_number, default 0, meaning the slave index this arbiter serves.
REQ-004 SHALL have parameter pending_depth, default 8, meaning order-queue depth (power of two).
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  synchronous, active-high reset.
- master_write_addr_fifo_empty  input  1 x [masters-1:0]  per-master AW FIFO empty.
- write_addr_forward_dest_slave  input  $clog2(slaves) x [masters-1:0]  per-master AW destination slave.
- master_write_data_fifo_empty  input  1 x [masters-1:0]  per-master W FIFO empty.
- master_write_data_last  input  1 x [masters-1:0]  per-master front-entry WLAST.
- slave_write_addr_fifo_full  input  1  this slave's AW FIFO full.
- slave_write_data_fifo_full  input  1  this slave's W FIFO full.
- aw_push  output  1  AW transfer accepted this cycle.
- grant_write_addr_master  output  $clog2(masters)  master supplying AW.
- w_push  output  1  W beat accepted this cycle.
- grant_write_data_master  output  $clog2(masters)  master supplying W.
- order_queue_full  output  1  order queue full.

Function
REQ-006 SHALL define request r[m] = ~master_write_addr_fifo_empty[m] & (write_addr_forward_dest_slave[m] == i_am_slave_number).
REQ-007 SHALL select AW winner combinationally by round-robin from pointer rr_ptr: first m with r[m] scanning rr_ptr, rr_ptr+1, ... modulo masters.
REQ-008 SHALL assert aw_push = (any r[m]) & ~slave_write_addr_fifo_full & ~order_queue_full, zero-latency, with grant_write_addr_master = winner.
REQ-009 SHALL drive grant_write_addr_master = rr_ptr when no request exists.
REQ-010 SHALL, on aw_push, update rr_ptr next cycle to winner+1, wrapping masters-1 -> 0; otherwise hold rr_ptr.
REQ-011 SHALL, on aw_push, enqueue winner index into an order queue of pending_depth entries, preserving AW acceptance order.
REQ-012 SHALL drive grant_write_data_master = order-queue head index; 0 when queue empty.
REQ-013 SHALL assert w_push = ~queue_empty & ~master_write_data_fifo_empty[head] & ~slave_write_data_fifo_full.
REQ-014 SHALL dequeue the head on (w_push & master_write_data_last[head]); beats of one burst SHALL never interleave with another master's.
REQ-015 SHALL support simultaneous enqueue and dequeue in one cycle: count unchanged, both pointers advance.
REQ-016 SHALL keep an occupancy counter of $clog2(pending_depth)+1 bits; order_queue_full = (count == pending_depth); read/write pointers wrap at pending_depth.
REQ-017 SHALL allow a W beat for a queued burst whose AW was accepted in the same cycle only from the following cycle (enqueue-to-head latency 1).
REQ-018 SHALL block aw_push when full even if a dequeue occurs that cycle (no full bypass).

Reset
REQ-019 SHALL, while ARESET high at a clock edge, clear rr_ptr, queue pointers and count to 0.
REQ-020 SHALL, during and after reset, produce aw_push=0, w_push=0, order_queue_full=0, grant_write_data_master=0, grant_write_addr_master=0 absent requests.
REQ-021 SHALL, on reset mid-burst, discard all queued entries; no w_push until a new AW is accepted.

Configuration
REQ-022 SHALL, with macro FWD_WRITE_ARB_FIXED_PRIO_EN defined, replace round-robin by fixed priority (lowest requesting index wins, rr_ptr removed/constant 0).
REQ-023 SHALL, with FWD_WRITE_ARB_FIXED_PRIO_EN undefined, use round-robin per REQ-007/REQ-010; all other behaviour identical.

Verification
REQ-024 SHALL cover: masters 0 and 1 both request slave 0 continuously, no backpressure -> aw_push every cycle, grants alternate 0,1,0,1 (fixed-prio build: always 0).
REQ-025 SHALL cover: AW from master 1 (len 3) then master 0 (len 1), W FIFOs both non-empty -> w_push grants master 1 for 4 beats, then master 0 for 2 beats, head dequeued on each WLAST.
REQ-026 SHALL cover: 8 AWs accepted, no W data -> order_queue_full=1 after 8th, aw_push=0 on 9th request until one WLAST beat dequeues.
REQ-027 SHALL cover: slave_write_data_fifo_full=1 for 3 cycles mid-burst -> w_push=0 those cycles, head unchanged, burst resumes with same master.
REQ-028 SHALL cover: ARESET pulsed 1 cycle with 3 queued entries -> count=0, w_push=0, grant_write_data_master=0 next cycle.
REQ-029 SHALL cover: request with dest slave 1 at arbiter i_am_slave_number=0 -> aw_push stays 0.

Source files
------------

// File: rtl/forward_write_arbiter.sv
// Write-channel arbiter for one crossbar slave: round-robin AW grant, with an order queue that keeps W bursts in AW order.
// Define FWD_WRITE_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index fixed priority.
module forward_write_arbiter #(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  parameter int pending_depth     = 8
) (
  input  logic                                        ACLK,
  input  logic                                        ARESET,
  input  logic [masters-1:0]                          master_write_addr_fifo_empty,
  input  logic [masters-1:0][$clog2(slaves)-1:0]      write_addr_forward_dest_slave,
  input  logic [masters-1:0]                          master_write_data_fifo_empty,
  input  logic [masters-1:0]                          master_write_data_last,
  input  logic                                        slave_write_addr_fifo_full,
  input  logic                                        slave_write_data_fifo_full,
  output logic                                        aw_push,
  output logic [$clog2(masters)-1:0]                  grant_write_addr_master,
  output logic                                        w_push,
  output logic [$clog2(masters)-1:0]                  grant_write_data_master,
  output logic                                        order_queue_full
);

  localparam int          MW = $clog2(masters);
  localparam int          SW = $clog2(slaves);
  localparam int          PW = $clog2(pending_depth);
  localparam int unsigned M  = masters;

  logic [masters-1:0] req;
  logic [MW-1:0]      rr_ptr;
  logic [MW-1:0]      winner;
  logic               any_req;

  logic [MW-1:0]      order_mem [pending_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;
  logic [MW-1:0]      head;
  logic               queue_empty;
  logic               queue_full;
  logic               enq;
  logic               deq;

  always_comb begin
    for (int unsigned m = 0; m < M; m++) begin
      req[m] = ~master_write_addr_fifo_empty[m] &
               (write_addr_forward_dest_slave[m] == SW'(i_am_slave_number));
    end
  end

`ifdef FWD_WRITE_ARB_FIXED_PRIO_EN
  always_comb rr_ptr = '0;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (!any_req && req[i]) begin
        any_req = 1'b1;
        winner  = MW'(i);
      end
    end
  end
`else
  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = rr_ptr;
    any_req = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      idx = (32'(rr_ptr) + i) % M;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = MW'(idx);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr <= '0;
    end else if (aw_push) begin
      rr_ptr <= (32'(winner) == M - 1) ? '0 : winner + MW'(1);
    end
  end
`endif

  assign queue_empty = (count == '0);
  assign queue_full  = (count == (PW+1)'(pending_depth));
  assign head        = order_mem[rd_ptr];

  // Outputs are gated by ARESET so nothing is pushed while queued state is being discarded.
  always_comb begin
    aw_push                 = any_req & ~slave_write_addr_fifo_full & ~queue_full & ~ARESET;
    grant_write_addr_master = ARESET ? '0 : winner;
    w_push                  = ~queue_empty & ~master_write_data_fifo_empty[head] &
                              ~slave_write_data_fifo_full & ~ARESET;
    grant_write_data_master = (queue_empty | ARESET) ? '0 : head;
    order_queue_full        = queue_full & ~ARESET;
    enq                     = aw_push;
    deq                     = w_push & master_write_data_last[head];
  end

  always_ff @(posedge ACLK) begin
    if (enq) begin
      order_mem[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_forward_write_arbiter.sv
// Scoreboard bench for forward_write_arbiter: expected AW/W grants are queued by the stimulus and checked by a monitor.
module tb_forward_write_arbiter;

  localparam int M = 2;
  localparam int S = 2;
  localparam int D = 8;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [1:0]      aw_empty;
  logic [1:0][0:0] dest;
  logic [1:0]      w_empty;
  logic [1:0]      w_last;
  logic            aw_full;
  logic            w_full;
  logic            aw_push;
  logic            w_push;
  logic            oq_full;
  logic [0:0]      g_aw;
  logic [0:0]      g_w;

  int total = 0;
  int bad   = 0;
  int aw_exp[$];
  int w_exp[$];

  always #5 ACLK = ~ACLK;

  forward_write_arbiter #(
    .masters(M), .slaves(S), .i_am_slave_number(0), .pending_depth(D)
  ) dut (
    .ACLK                          (ACLK),
    .ARESET                        (ARESET),
    .master_write_addr_fifo_empty  (aw_empty),
    .write_addr_forward_dest_slave (dest),
    .master_write_data_fifo_empty  (w_empty),
    .master_write_data_last        (w_last),
    .slave_write_addr_fifo_full    (aw_full),
    .slave_write_data_fifo_full    (w_full),
    .aw_push                       (aw_push),
    .grant_write_addr_master       (g_aw),
    .w_push                        (w_push),
    .grant_write_data_master       (g_w),
    .order_queue_full              (oq_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ae, input logic [1:0] d, input logic [1:0] we,
                       input logic [1:0] wl, input logic wf);
    aw_empty = ae;
    dest[0]  = d[0];
    dest[1]  = d[1];
    w_empty  = we;
    w_last   = wl;
    w_full   = wf;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  always @(negedge ACLK) begin
    if (aw_push === 1'b1) begin
      if (aw_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL aw_unexpected: got push grant %0d want no push", g_aw);
      end else begin
        check("aw_grant", 32'(g_aw), 32'(aw_exp.pop_front()));
      end
    end
    if (w_push === 1'b1) begin
      if (w_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w_unexpected: got push grant %0d want no push", g_w);
      end else begin
        check("w_grant", 32'(g_w), 32'(w_exp.pop_front()));
      end
    end
  end

  initial begin
    ARESET  = 1'b1;
    aw_full = 1'b0;
    drive(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
    tick();
    tick();
    @(negedge ACLK);
    check("rst_aw_push", 32'(aw_push), 0);
    check("rst_w_push", 32'(w_push), 0);
    check("rst_full", 32'(oq_full), 0);
    check("rst_g_w", 32'(g_w), 0);
    check("rst_g_aw", 32'(g_aw), 0);
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_aw_push", 32'(aw_push), 0);
    check("post_rst_g_aw", 32'(g_aw), 0);
    tick();

    // Both masters request continuously
`ifdef FWD_WRITE_ARB_FIXED_PRIO_EN
    aw_exp.push_back(0); aw_exp.push_back(0); aw_exp.push_back(0); aw_exp.push_back(0);
`else
    aw_exp.push_back(0); aw_exp.push_back(1); aw_exp.push_back(0); aw_exp.push_back(1);
`endif
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
      tick();
    end
    do_reset();

    // Three entries queued (head = master 1), then a reset pulse
`ifdef FWD_WRITE_ARB_FIXED_PRIO_EN
    aw_exp.push_back(1); aw_exp.push_back(0); aw_exp.push_back(0);
`else
    aw_exp.push_back(1); aw_exp.push_back(0); aw_exp.push_back(1);
`endif
    drive(2'b01, 2'b00, 2'b11, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    tick();
    tick();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rstq_w_push_during", 32'(w_push), 0);
    check("rstq_g_w_during", 32'(g_w), 0);
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      check("rstq_w_push_after", 32'(w_push), 0);
      check("rstq_g_w_after", 32'(g_w), 0);
      check("rstq_full_after", 32'(oq_full), 0);
      tick();
    end

    // Master 1 burst of 4 then master 0 burst of 2
    aw_exp.push_back(1); aw_exp.push_back(0);
    w_exp.push_back(1); w_exp.push_back(1); w_exp.push_back(1); w_exp.push_back(1);
    w_exp.push_back(0); w_exp.push_back(0);
    drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge ACLK);
    check("enq_to_head_latency", 32'(w_push), 0);
    tick();
    drive(2'b10, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    tick();
    drive(2'b11, 2'b00, 2'b00, 2'b10, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b01, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge ACLK);
    check("drained_w_push", 32'(w_push), 0);
`ifdef FWD_WRITE_ARB_FIXED_PRIO_EN
    check("idle_g_aw_ptr", 32'(g_aw), 0);
`else
    check("idle_g_aw_ptr", 32'(g_aw), 1);
`endif
    tick();

    // W backpressure mid-burst with a second burst queued behind
    aw_exp.push_back(0); aw_exp.push_back(1);
    w_exp.push_back(0); w_exp.push_back(0); w_exp.push_back(0); w_exp.push_back(0);
    w_exp.push_back(1);
    drive(2'b10, 2'b00, 2'b11, 2'b00, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
      @(negedge ACLK);
      check("bp_w_push", 32'(w_push), 0);
      check("bp_head_kept", 32'(g_w), 0);
      tick();
    end
    drive(2'b11, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b01, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b00, 2'b10, 1'b0); tick();
    drive(2'b11, 2'b00, 2'b11, 2'b00, 1'b0); tick();

    // Fill the order queue, no W data
    do_reset();
    for (int i = 0; i < 8; i++) aw_exp.push_back(0);
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 2'b00, 2'b11, 2'b00, 1'b0);
      if (i == 7) begin
        @(negedge ACLK);
        check("full_before_8th", 32'(oq_full), 0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      check("full_set", 32'(oq_full), 1);
      check("full_blocks_aw", 32'(aw_push), 0);
      tick();
    end
    w_exp.push_back(0);
    drive(2'b10, 2'b00, 2'b10, 2'b01, 1'b0);
    @(negedge ACLK);
    check("no_full_bypass", 32'(aw_push), 0);
    check("full_during_deq", 32'(oq_full), 1);
    tick();
    aw_exp.push_back(0);
    drive(2'b10, 2'b00, 2'b11, 2'b00, 1'b0);
    @(negedge ACLK);
    check("full_cleared", 32'(oq_full), 0);
    check("aw_after_deq", 32'(aw_push), 1);
    tick();
    drive(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
    @(negedge ACLK);
    check("full_again", 32'(oq_full), 1);
    tick();

    // Requests addressed to the other slave
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b11, 2'b11, 2'b00, 1'b0);
      @(negedge ACLK);
      check("other_slave_aw_push", 32'(aw_push), 0);
      tick();
    end

    drive(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
    tick();
    tick();
    check("aw_exp_left", 32'(aw_exp.size()), 0);
    check("w_exp_left", 32'(w_exp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
